// File: rtl/toi2s_pkg.sv
// Shared types and default sizing for the multi-channel PWM block.
package toi2s_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_t;

  localparam int PWM_MC_N_CH = 4;
  localparam int PWM_MC_DW   = 8;

endpackage

// File: rtl/pwm_mc_ch.sv
// One PWM channel: pending/active duty pair, compare against the shared counter, output register.
module pwm_mc_ch
  import toi2s_pkg::*;
#(
  parameter int DW = PWM_MC_DW
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          enable,
  input  logic          boundary,
  input  logic          load,
  input  logic [DW-1:0] duty_in,
  input  logic [DW-1:0] cnt,
  input  logic          pol,
  output logic          pwm_out
);

  logic [DW-1:0] duty_pend;
  logic [DW-1:0] duty_act;
  logic [DW-1:0] duty_eff;
  logic          raw;

  // The boundary cycle is the first cycle of the new period, so it already
  // compares against the duty being promoted in that same cycle.
  always_comb begin
    duty_eff = boundary ? duty_pend : duty_act;
    raw      = (cnt < duty_eff);
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      duty_pend <= '0;
      duty_act  <= '0;
      pwm_out   <= 1'b0;
    end else begin
      if (load) begin
        duty_pend <= duty_in;
      end
      if (!enable || boundary) begin
        duty_act <= duty_pend;
      end
      pwm_out <= enable ? (raw ^ pol) : pol;
    end
  end

endmodule

// File: rtl/pwm_mc.sv
// Multi-channel PWM: one shared edge/center-aligned timebase driving N_CH compare channels.
module pwm_mc
  import toi2s_pkg::*;
#(
  parameter int N_CH = PWM_MC_N_CH,
  parameter int DW   = PWM_MC_DW
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               enable,
  input  logic               center_mode,
  input  logic [N_CH*DW-1:0] duty_in,
  input  logic               load,
  input  logic [N_CH-1:0]    pol,
  output logic [N_CH-1:0]    pwm_out,
  output logic               period_start,
  output logic               upd_pending
);

  localparam logic [DW-1:0] CNT_MAX = {{(DW-1){1'b1}}, 1'b0};

  // load is a single-cycle strobe with no back-pressure: it is always accepted,
  // and a later strobe in the same period simply overwrites the pending duties.

  logic [DW-1:0] cnt, cnt_nxt;
  pwm_dir_t      dir, dir_nxt;
  pwm_mode_t     mode_act, mode_nxt;
  logic          boundary;

  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    mode_nxt = mode_act;
    boundary = enable && (cnt == '0) && (dir == DIR_UP);
    if (!enable) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else begin
      if (boundary) begin
        mode_nxt = pwm_mode_t'(center_mode);
      end
      // Leaving the boundary cycle both modes step 0 -> 1, so the old mode is safe here.
      if (mode_act == PWM_EDGE) begin
        cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + DW'(1);
      end else if (dir == DIR_UP) begin
        if (cnt == CNT_MAX) dir_nxt = DIR_DOWN;
        else                cnt_nxt = cnt + DW'(1);
      end else begin
        if (cnt == '0) dir_nxt = DIR_UP;
        else           cnt_nxt = cnt - DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      mode_act     <= PWM_EDGE;
      period_start <= 1'b0;
      upd_pending  <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      mode_act     <= mode_nxt;
      period_start <= boundary;
      if (!enable)       upd_pending <= 1'b0;
      else if (load)     upd_pending <= 1'b1;
      else if (boundary) upd_pending <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_mc_ch #(.DW(DW)) u_ch (
      .clk      (clk),
      .resetb   (resetb),
      .enable   (enable),
      .boundary (boundary),
      .load     (load),
      .duty_in  (duty_in[i*DW +: DW]),
      .cnt      (cnt),
      .pol      (pol[i]),
      .pwm_out  (pwm_out[i])
    );
  end

endmodule

// File: doc/pwm_mc.md
PWM_MC -- requirements
Module: pwm_mc

Interface
REQ-001 Parameter N_CH, default 4: number of PWM channels, legal range 1..16.
REQ-002 Parameter DW, default 8: duty/counter width in bits, legal range 4..16; M = 2^DW-2.
REQ-003 clk  input  1: single clock; all logic is rising-edge clocked.
REQ-004 resetb  input  1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 enable  input  1: run when high; idle when low.
REQ-006 center_mode  input  1: 0 = edge-aligned, 1 = center-aligned; takes effect only at a period boundary.
REQ-007 duty_in  input  N_CH*DW: packed duties; channel i occupies bits [i*DW+DW-1 : i*DW].
REQ-008 load  input  1: one-cycle strobe that captures duty_in into the pending (shadow) registers.
REQ-009 pol  input  N_CH: per-channel output inversion, applied to both active and idle levels.
REQ-010 pwm_out  output  N_CH: registered PWM outputs.
REQ-011 period_start  output  1: registered one-cycle pulse marking the first output cycle of each period.
REQ-012 upd_pending  output  1: high from the cycle after load until the pending duties reach the active registers.

Function
REQ-013 Counter cnt, DW bits. Edge mode counts 0..M and then wraps to 0, so the period is 2^DW-1 cycles.
REQ-014 Center mode counts up 0..M, holds direction-down, then counts M..0, repeating each endpoint once, so the period is 2*(2^DW-1) cycles.
REQ-015 Channel raw level = (cnt < duty_act[i]); duty 0 gives constant low; duty >= 2^DW-1 gives constant high.
REQ-016 pwm_out[i] at cycle t+1 = raw level at cycle t XOR pol[i], giving a fixed latency of one cycle.
REQ-017 Period boundary is the cycle where cnt = 0 and direction = up, with enable high; it is asserted on the first enabled cycle and on every wrap.
REQ-018 At a period boundary: duty_act <= duty_pend, mode_act <= center_mode, upd_pending clears, and period_start pulses one cycle later, aligned with pwm_out.
REQ-019 load asserted in any cycle: duty_pend <= duty_in, and upd_pending sets on the next cycle.
REQ-020 load in the same cycle as a boundary: the boundary transfers the old duty_pend; the new value is applied at the next boundary and upd_pending stays high.
REQ-021 Two loads within one period: the last one wins; no queueing.
REQ-022 center_mode changes mid-period are ignored until the next boundary; the current period completes in the old mode.
REQ-023 enable low: cnt <= 0, direction <= up, duty_act <= duty_pend every cycle, upd_pending <= 0, pwm_out <= pol (inactive level), period_start <= 0.
REQ-024 enable deasserted mid-period: the period is abandoned at once, with no completion of the current period.

Reset
REQ-025 resetb low: cnt = 0, direction = up, duty_pend = duty_act = 0, mode_act = edge, pwm_out = 0, period_start = 0, upd_pending = 0.
REQ-026 Reset asserted mid-period overrides load and enable in the same cycle; the first boundary after release occurs on the first cycle with enable high.

Structure
REQ-027 toi2s_pkg holds pwm_mode_t (PWM_EDGE, PWM_CENTER) and the default constants PWM_MC_N_CH = 4 and PWM_MC_DW = 8.
REQ-028 Shared timebase: counter, direction, mode_act, boundary detect and period_start are implemented once in pwm_mc.
REQ-029 One sub-module, pwm_mc_ch, is instantiated N_CH times via generate; it holds duty_pend, duty_act, the compare logic and the output register.
REQ-030 The sys_cfg duty field of the register bank is widened to N_CH*DW, and load is driven by the register-bank write strobe.

Verification
REQ-031 Edge mode, DW=8, duty=64, enable high → 255-cycle period with 64 high cycles; period_start every 255 cycles.
REQ-032 Center mode, DW=8, duty=64 → 510-cycle period with 128 contiguous high cycles, centered on cnt = 0 at the down/up turnaround.
REQ-033 Duty 0 and duty 255 on channels 0 and 1, pol = 0b0010 → ch0 constant low; ch1 constant low (inverted full-on); ch2 and ch3 unaffected.
REQ-034 Load duty 200 at cnt = 100, then load 10 at cnt = 150 → old duty holds until the boundary, then duty 10 applies; upd_pending high from cnt 101 to the boundary.
REQ-035 Load exactly at the boundary cycle, and toggle center_mode mid-period → both take effect one period later, with no glitch in the current period.
REQ-036 resetb low at cnt = 77, then enable low→high → all outputs 0 during reset; after release, pwm_out = pol while disabled; period_start fires on the first enabled cycle + 1.
